stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 87 ++++++++
 rtl/stall_ctrl_dec.sv | 91 +++++++++
 rtl/stall_ctrl.sv | 89 ++++++++
 tb/tb_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared MIPS opcode/funct constants, Tuse/Tnew encodings and the per-instruction
// classification record used by the hazard unit.
package stall_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_cls_e;

  // Unused source/destination fields hold register 0, which never hazards.
  typedef struct packed {
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    md_cls_e    md;
  } dec_t;

  function automatic logic [1:0] tnew_at_m(input logic [1:0] tnew_e);
    return (tnew_e == T0) ? T0 : tnew_e - 2'd1;
  endfunction

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_dec.sv
// Per-stage instruction classifier: source registers with Tuse, destination with
// E-stage Tnew, and mult/div class.
module stall_dec
  import stall_ctrl_pkg::*;
(
  input  logic [31:0] ins,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = ins[31:26];
  assign fn = ins[5:0];
  assign rs = ins[25:21];
  assign rt = ins[20:16];
  assign rd = ins[15:11];

  always_comb begin
    dec = '0;
    if (ins != '0) begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_JR: begin
              dec.rs = rs; dec.tuse_rs = T0;
            end
            FN_JALR: begin
              dec.rs = rs; dec.tuse_rs = T0;
              dec.dst = rd; dec.tnew = T0;
            end
            FN_MFHI, FN_MFLO: begin
              dec.dst = rd; dec.tnew = T1; dec.md = MD_HILO;
            end
            FN_MTHI, FN_MTLO: begin
              dec.rs = rs; dec.tuse_rs = T1; dec.md = MD_HILO;
            end
            // Operands are consumed when the unit starts in E, like an ALU op.
            FN_MULT, FN_MULTU: begin
              dec.rs = rs; dec.tuse_rs = T1;
              dec.rt = rt; dec.tuse_rt = T1; dec.md = MD_MUL;
            end
            FN_DIV, FN_DIVU: begin
              dec.rs = rs; dec.tuse_rs = T1;
              dec.rt = rt; dec.tuse_rt = T1; dec.md = MD_DIV;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              dec.rt = rt; dec.tuse_rt = T1;
              dec.dst = rd; dec.tnew = T1;
            end
            FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
              dec.rs = rs; dec.tuse_rs = T1;
              dec.rt = rt; dec.tuse_rt = T1;
              dec.dst = rd; dec.tnew = T1;
            end
            default: ;
          endcase
        end
        OP_BEQ, OP_BNE: begin
          dec.rs = rs; dec.tuse_rs = T0;
          dec.rt = rt; dec.tuse_rt = T0;
        end
        OP_JAL: begin
          dec.dst = 5'd31; dec.tnew = T0;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
          dec.rs = rs; dec.tuse_rs = T1;
          dec.dst = rt; dec.tnew = T1;
        end
        OP_LUI: begin
          dec.dst = rt; dec.tnew = T1;
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          dec.rs = rs; dec.tuse_rs = T1;
          dec.dst = rt; dec.tnew = T2;
        end
        OP_SB, OP_SH, OP_SW: begin
          dec.rs = rs; dec.tuse_rs = T1;
          dec.rt = rt; dec.tuse_rt = T2;
        end
        OP_J: ;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data-hazard detection plus mult/div busy
// tracking, with a running count of stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InsD,
  input  logic [31:0] InsE,
  input  logic [31:0] InsM,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        ID_EX_Clr,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [31:0] StallCnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  dec_t dec_d;
  dec_t dec_e;
  dec_t dec_m;

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [1:0]       tnew_m;
  logic             data_stall;
  logic             md_start;
  logic             md_busy;
  logic             md_stall;
  logic             stall;

  stall_dec u_dec_d (.ins(InsD), .dec(dec_d));
  stall_dec u_dec_e (.ins(InsE), .dec(dec_e));
  stall_dec u_dec_m (.ins(InsM), .dec(dec_m));

  always_comb begin
    tnew_m     = tnew_at_m(dec_m.tnew);
    data_stall = hazard(dec_d.rs, dec_d.tuse_rs, dec_e.dst, dec_e.tnew)
               | hazard(dec_d.rt, dec_d.tuse_rt, dec_e.dst, dec_e.tnew)
               | hazard(dec_d.rs, dec_d.tuse_rs, dec_m.dst, tnew_m)
               | hazard(dec_d.rt, dec_d.tuse_rt, dec_m.dst, tnew_m);
    md_start   = (dec_e.md == MD_MUL) || (dec_e.md == MD_DIV);
    md_busy    = (busy_cnt_q != '0);
    md_stall   = (dec_d.md != MD_NONE) && (md_start || md_busy);
    stall      = data_stall || md_stall;

    // A new start reloads rather than accumulates.
    busy_cnt_d = busy_cnt_q;
    if (dec_e.md == MD_MUL) begin
      busy_cnt_d = MULT_LOAD;
    end else if (dec_e.md == MD_DIV) begin
      busy_cnt_d = DIV_LOAD;
    end else if (md_busy) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end

    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PC_En     = ~stall;
  assign IF_ID_En  = ~stall;
  assign ID_EX_Clr = stall;
  assign MD_Start  = md_start;
  assign MD_Busy   = md_busy;
  assign StallCnt  = stall_cnt_q;

  // Fields each stage's role never reads; the name keeps them out of unused-signal lint.
  logic unused_dec;
  assign unused_dec = ^{dec_d.dst, dec_d.tnew,
                        dec_e.rs, dec_e.tuse_rs, dec_e.rt, dec_e.tuse_rt,
                        dec_m.rs, dec_m.tuse_rs, dec_m.rt, dec_m.tuse_rt, dec_m.md};

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed vector table, multi-cycle mult/div
// sequences, and randomized traffic against an instruction-class reference model.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InsD, InsE, InsM;
  logic        PC_En, IF_ID_En, ID_EX_Clr, MD_Start, MD_Busy;
  logic [31:0] StallCnt;

  int n_cmp = 0;
  int n_bad = 0;

  stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst(rst), .InsD(InsD), .InsE(InsE), .InsM(InsM),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .ID_EX_Clr(ID_EX_Clr),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: instructions built from their class ----------------
  typedef struct {
    logic [31:0] w;
    int s0, u0, s1, u1;   // source regs (0 = none) and their Tuse
    int dst, tnew;        // destination (0 = none) and Tnew while in E
    int md;               // 0 none, 1 mult, 2 div, 3 hi/lo access
  } ins_t;

  localparam int NK = 21;
  localparam logic [31:0] MFLO2 = 32'h00001012;

  function automatic ins_t make_ins(input int kind, input logic [4:0] a,
                                    input logic [4:0] b, input logic [4:0] c);
    ins_t r;
    r.w = '0; r.s0 = 0; r.u0 = 0; r.s1 = 0; r.u1 = 0; r.dst = 0; r.tnew = 0; r.md = 0;
    case (kind)
      1:  begin r.w = {6'h00, a, b, c, 5'd0, 6'h21}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.dst = c; r.tnew = 1; end
      2:  begin r.w = {6'h00, a, b, c, 5'd0, 6'h23}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.dst = c; r.tnew = 1; end
      3:  begin r.w = {6'h0d, a, b, 16'h1234}; r.s0 = a; r.u0 = 1; r.dst = b; r.tnew = 1; end
      4:  begin r.w = {6'h23, a, b, 16'h0004}; r.s0 = a; r.u0 = 1; r.dst = b; r.tnew = 2; end
      5:  begin r.w = {6'h2b, a, b, 16'h0008}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 2; end
      6:  begin r.w = {6'h0f, 5'd0, b, 16'hbeef}; r.dst = b; r.tnew = 1; end
      7:  begin r.w = {6'h04, a, b, 16'h0003}; r.s0 = a; r.u0 = 0; r.s1 = b; r.u1 = 0; end
      8:  begin r.w = {6'h05, a, b, 16'h0003}; r.s0 = a; r.u0 = 0; r.s1 = b; r.u1 = 0; end
      9:  begin r.w = {6'h00, a, 15'd0, 6'h08}; r.s0 = a; r.u0 = 0; end
      10: begin r.w = {6'h03, 26'h0000010}; r.dst = 31; r.tnew = 0; end
      11: begin r.w = {6'h00, a, 5'd0, c, 5'd0, 6'h09}; r.s0 = a; r.u0 = 0; r.dst = c; r.tnew = 0; end
      12: begin r.w = {6'h00, 10'd0, c, 5'd0, 6'h10}; r.dst = c; r.tnew = 1; r.md = 3; end
      13: begin r.w = {6'h00, 10'd0, c, 5'd0, 6'h12}; r.dst = c; r.tnew = 1; r.md = 3; end
      14: begin r.w = {6'h00, a, 15'd0, 6'h11}; r.s0 = a; r.u0 = 1; r.md = 3; end
      15: begin r.w = {6'h00, a, b, 10'd0, 6'h18}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.md = 1; end
      16: begin r.w = {6'h00, a, b, 10'd0, 6'h19}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.md = 1; end
      17: begin r.w = {6'h00, a, b, 10'd0, 6'h1a}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.md = 2; end
      18: begin r.w = {6'h00, a, b, 10'd0, 6'h1b}; r.s0 = a; r.u0 = 1; r.s1 = b; r.u1 = 1; r.md = 2; end
      19: begin r.w = {6'h02, 26'h0000040}; end
      20: begin r.w = {6'h00, 5'd0, b, c, 5'd2, 6'h00}; r.s1 = b; r.u1 = 1; r.dst = c; r.tnew = 1; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit src_hz(input int s, input int u, input ins_t p, input bit at_m);
    int tn;
    tn = at_m ? ((p.tnew > 0) ? p.tnew - 1 : 0) : p.tnew;
    return (s != 0) && (s == p.dst) && (u < tn);
  endfunction

  function automatic bit model_stall(input ins_t d, input ins_t e, input ins_t m, input int busy);
    bit data_hz, md_hz;
    data_hz = src_hz(d.s0, d.u0, e, 1'b0) || src_hz(d.s1, d.u1, e, 1'b0) ||
              src_hz(d.s0, d.u0, m, 1'b1) || src_hz(d.s1, d.u1, m, 1'b1);
    md_hz   = (d.md != 0) && (e.md == 1 || e.md == 2 || busy > 0);
    return data_hz || md_hz;
  endfunction

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 3));
  endfunction

  // ---------------- helpers ----------------
  task automatic reset_pulse();
    rst = 1'b1; InsD = '0; InsE = '0; InsM = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic md_seq(input string nm, input logic [31:0] md_ins, input int exp_n);
    int n_st, n_bz, n_sp;
    n_st = 0; n_bz = 0; n_sp = 0;
    reset_pulse();
    InsE = md_ins; InsD = MFLO2;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (!PC_En) n_st++;
      if (MD_Busy) n_bz++;
      if (MD_Start) n_sp++;
      @(posedge clk); #1;
      InsE = '0;
    end
    check({nm, "_start_cycles"}, n_sp, 1);
    check({nm, "_busy_cycles"}, n_bz, exp_n - 1);
    check({nm, "_stall_cycles"}, n_st, exp_n);
    check({nm, "_stallcnt"}, StallCnt, exp_n);
  endtask

  typedef struct {
    string nm;
    logic [31:0] d, e, m;
    bit stall, start;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; InsD = '0; InsE = '0; InsM = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", MD_Busy, 0);
    check("reset_stallcnt", StallCnt, 0);
    check("reset_ctl", {PC_En, IF_ID_En, ID_EX_Clr, MD_Start}, 4'b1100);
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    vecs.push_back('{"load_use",     32'h00421821, 32'h8C220000, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{"alu_beq_e",    32'h10600004, 32'h00211821, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{"alu_beq_m",    32'h10600004, 32'h0,        32'h00211821, 1'b0, 1'b0});
    vecs.push_back('{"lw_sw_data",   32'hAC220000, 32'h8C220000, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"reg0",         32'h00001821, 32'h00210021, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"lw_m_beq",     32'h10400004, 32'h0,        32'h8C220000, 1'b1, 1'b0});
    vecs.push_back('{"lw_m_addu",    32'h00421821, 32'h0,        32'h8C220000, 1'b0, 1'b0});
    vecs.push_back('{"lw_sw_base",   32'hAC450000, 32'h8C220000, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{"jal_e_jr",     32'h03E00008, 32'h0C000000, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"jal_m_jr",     32'h03E00008, 32'h0,        32'h0C000000, 1'b0, 1'b0});
    vecs.push_back('{"mult_mflo",    MFLO2,        32'h00220018, 32'h0,        1'b1, 1'b1});
    vecs.push_back('{"div_addu",     32'h00421821, 32'h0022001A, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"mfhi_beq",     32'h10400004, 32'h00001010, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{"lui_addu",     32'h00421821, 32'h3C020000, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"ori_jr",       32'h00400008, 32'h34220000, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{"all_nop",      32'h0,        32'h0,        32'h0,        1'b0, 1'b0});

    foreach (vecs[i]) begin
      reset_pulse();
      InsD = vecs[i].d; InsE = vecs[i].e; InsM = vecs[i].m;
      @(negedge clk);
      check({vecs[i].nm, "_ctl"}, {PC_En, IF_ID_En, ID_EX_Clr},
            vecs[i].stall ? 3'b001 : 3'b110);
      check({vecs[i].nm, "_start"}, MD_Start, vecs[i].start);
      @(posedge clk); #1;
      InsD = '0; InsE = '0; InsM = '0;
      check({vecs[i].nm, "_cnt"}, StallCnt, vecs[i].stall ? 1 : 0);
    end

    // ---------------- multi-cycle mult/div sequences ----------------
    md_seq("mult", 32'h00220018, 6);
    md_seq("div",  32'h0022001A, 11);

    // mult start, two busy cycles, then div start reloads the count to 10
    begin
      int n_bz;
      n_bz = 0;
      reset_pulse();
      InsD = MFLO2; InsE = 32'h00220018;
      @(posedge clk); #1 InsE = '0;
      repeat (2) @(posedge clk);
      #1 InsE = 32'h0022001A;
      @(negedge clk);
      check("reload_start", MD_Start, 1);
      @(posedge clk); #1 InsE = '0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (MD_Busy) n_bz++;
        @(posedge clk); #1;
      end
      check("reload_busy_cycles", n_bz, 10);
      check("reload_stallcnt", StallCnt, 14);
    end

    // reset on the third busy cycle of a divide
    reset_pulse();
    InsD = MFLO2; InsE = 32'h0022001A;
    @(posedge clk); #1 InsE = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("middiv_busy_before", MD_Busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("middiv_busy_after", MD_Busy, 0);
    check("middiv_stallcnt", StallCnt, 0);
    check("middiv_pc_en", PC_En, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("middiv_no_residual", {PC_En, MD_Busy, StallCnt}, {1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;

    // ---------------- randomized traffic vs reference model ----------------
    reset_pulse();
    begin
      int busy;
      logic [31:0] scnt;
      busy = 0; scnt = '0;
      for (int i = 0; i < 3000; i++) begin
        ins_t pd, pe, pm;
        bit r, st, sp;
        logic [4:0] ctl_exp;
        r  = ($urandom_range(0, 39) == 0);
        pd = make_ins($urandom_range(0, NK - 1), rreg(), rreg(), rreg());
        pe = make_ins($urandom_range(0, NK - 1), rreg(), rreg(), rreg());
        pm = make_ins($urandom_range(0, NK - 1), rreg(), rreg(), rreg());
        rst = r; InsD = pd.w; InsE = pe.w; InsM = pm.w;
        sp = (pe.md == 1) || (pe.md == 2);
        st = model_stall(pd, pe, pm, busy);
        ctl_exp = {~st, ~st, st, sp, (busy > 0)};
        @(negedge clk);
        check("rnd_ctl", {PC_En, IF_ID_En, ID_EX_Clr, MD_Start, MD_Busy}, ctl_exp);
        check("rnd_stallcnt", StallCnt, scnt);
        @(posedge clk);
        if (r) begin
          busy = 0; scnt = '0;
        end else begin
          if (st) scnt = scnt + 32'd1;
          if (pe.md == 1)      busy = 5;
          else if (pe.md == 2) busy = 10;
          else if (busy > 0)   busy = busy - 1;
        end
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
